prog_stream_tx: RTL and testbench

- Host-side transmitter for the peripheral datapath's serial instruction-load port.
- Accepts bytes through a valid/ready write interface into an internal FIFO.
- Emits each byte bit-serially, LSB first, on ser_data/ser_enable using the load framing the datapath expects.
- Once the programmed byte count has been sent, it holds enable for a tail, then drops ser_enable. That falling edge releases the CPU.

---
 rtl/prog_stream_tx.sv | 226 ++++++++++++++++++++++
 tb/tb_prog_stream_tx.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_stream_tx.sv
// prog_stream_tx: host-side transmitter for the datapath's serial instruction-load port.
// Bytes are written into an internal FIFO. After start they are sent LSB first on
// ser_data/ser_enable. Each byte is followed by GAP_CYCLES hold cycles, and the last
// byte by TAIL_CYCLES more. The falling edge of ser_enable then releases the CPU.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start, byte_count   transfer request pulse and byte count (sampled in IDLE)
//   wr_valid, wr_data   byte write offer into the FIFO
//   wr_ready            FIFO not full
//   ser_data            serial data to the datapath in_data
//   ser_enable          serial frame enable to the datapath
//   busy, done          transfer in progress / one-cycle end-of-transfer pulse
//   underrun            sticky: a byte was needed while the FIFO was empty
//   checksum            mod-256 sum of transmitted bytes (PROG_STREAM_CHECKSUM_EN only)
//
// Optional feature macro: PROG_STREAM_CHECKSUM_EN
module prog_stream_tx #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned MAX_BYTES   = 1024,
   parameter int unsigned GAP_CYCLES  = 1,
   parameter int unsigned TAIL_CYCLES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [$clog2(MAX_BYTES):0]   byte_count,
   input  logic                         wr_valid,
   input  logic [7:0]                   wr_data,
   output logic                         wr_ready,
   output logic                         ser_data,
   output logic                         ser_enable,
   output logic                         busy,
   output logic                         done,
   output logic                         underrun
`ifdef PROG_STREAM_CHECKSUM_EN
   ,
   output logic [7:0]                   checksum
`endif
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam int unsigned PW       = AW + 1;
   localparam int unsigned CW       = $clog2(MAX_BYTES) + 1;
   localparam int unsigned HOLD_MAX = (GAP_CYCLES > TAIL_CYCLES) ? GAP_CYCLES : TAIL_CYCLES;
   localparam int unsigned HW       = $clog2(HOLD_MAX + 1) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SHIFT,
      S_GAP,
      S_TAIL
   } state_t;

   state_t state_q, state_n;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic          fifo_empty, push, pop, wr_ready_n;
   logic [7:0]    head;

   logic [CW-1:0] remaining_q, remaining_n, adv_rem;
   logic [6:0]    shift_q, shift_n;
   logic [3:0]    bit_cnt_q, bit_cnt_n;
   logic [HW-1:0] hold_q, hold_n;
   logic          ser_data_n, ser_enable_n, busy_n, done_n, underrun_n;
   logic          advance, finish;

   // FIFO status and next pointers
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign push       = wr_valid && wr_ready;
   assign head       = mem[rd_ptr[AW-1:0]];
   assign wr_ptr_n   = wr_ptr + PW'(push);
   assign rd_ptr_n   = rd_ptr + PW'(pop);
   // wr_ready is registered as "not full" of the pointers it will see next cycle
   assign wr_ready_n = !((wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                         (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]));

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         wr_ready    <= 1'b1;
         remaining_q <= '0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         hold_q      <= '0;
         ser_data    <= 1'b0;
         ser_enable  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         state_q     <= state_n;
         wr_ptr      <= wr_ptr_n;
         rd_ptr      <= rd_ptr_n;
         wr_ready    <= wr_ready_n;
         remaining_q <= remaining_n;
         shift_q     <= shift_n;
         bit_cnt_q   <= bit_cnt_n;
         hold_q      <= hold_n;
         ser_data    <= ser_data_n;
         ser_enable  <= ser_enable_n;
         busy        <= busy_n;
         done        <= done_n;
         underrun    <= underrun_n;
      end
   end

   // Next-state and next-output logic. Outputs are computed one edge ahead so
   // a byte's bit 0 appears the cycle after the fetch decision (fall-through pop).
   always_comb begin
      state_n      = state_q;
      remaining_n  = remaining_q;
      shift_n      = shift_q;
      bit_cnt_n    = bit_cnt_q;
      hold_n       = hold_q;
      ser_data_n   = ser_data;
      ser_enable_n = ser_enable;
      busy_n       = busy;
      done_n       = 1'b0;
      underrun_n   = underrun;
      pop          = 1'b0;
      advance      = 1'b0;
      finish       = 1'b0;
      adv_rem      = remaining_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               underrun_n = 1'b0;
               if (byte_count != '0) begin
                  remaining_n = byte_count;
                  busy_n      = 1'b1;
                  state_n     = S_FETCH;
               end else begin
                  done_n = 1'b1;
               end
            end
         end
         S_FETCH: begin
            advance = 1'b1;
         end
         S_SHIFT: begin
            if (bit_cnt_q != 4'd8) begin
               ser_data_n = shift_q[0];
               shift_n    = {1'b0, shift_q[6:1]};
               bit_cnt_n  = bit_cnt_q + 4'd1;
            end else begin
               // bit 7 is on the line; the byte is accounted for here
               remaining_n = remaining_q - CW'(1);
               if (GAP_CYCLES != 0) begin
                  hold_n  = HW'(1);
                  state_n = S_GAP;
               end else begin
                  advance = 1'b1;
                  adv_rem = remaining_q - CW'(1);
               end
            end
         end
         S_GAP: begin
            if (hold_q < HW'(GAP_CYCLES)) hold_n = hold_q + HW'(1);
            else                          advance = 1'b1;
         end
         S_TAIL: begin
            if (hold_q < HW'(TAIL_CYCLES)) hold_n = hold_q + HW'(1);
            else                           finish = 1'b1;
         end
         default: state_n = S_IDLE;
      endcase

      // Byte boundary: start the next byte, stall on an empty FIFO, or enter the tail
      if (advance) begin
         if (adv_rem != '0) begin
            if (!fifo_empty) begin
               pop          = 1'b1;
               ser_enable_n = 1'b1;
               ser_data_n   = head[0];
               shift_n      = head[7:1];
               bit_cnt_n    = 4'd1;
               state_n      = S_SHIFT;
            end else begin
               underrun_n = 1'b1;
               state_n    = S_FETCH;
            end
         end else if (TAIL_CYCLES != 0) begin
            hold_n  = HW'(1);
            state_n = S_TAIL;
         end else begin
            finish = 1'b1;
         end
      end

      if (finish) begin
         ser_enable_n = 1'b0;
         done_n       = 1'b1;
         busy_n       = 1'b0;
         state_n      = S_IDLE;
      end
   end

`ifdef PROG_STREAM_CHECKSUM_EN
   logic [7:0] checksum_n;

   // Running mod-256 sum of popped bytes; cleared by an accepted start
   always_comb begin
      checksum_n = checksum;
      if (state_q == S_IDLE && start) checksum_n = '0;
      else if (pop)                   checksum_n = checksum + head;
   end

   always_ff @(posedge clk) begin
      if (rst) checksum <= '0;
      else     checksum <= checksum_n;
   end
`endif

endmodule

// File: tb/tb_prog_stream_tx.sv
// tb_prog_stream_tx: self-checking bench for prog_stream_tx (default parameters).
// Expected serial streams are built from the byte list: 8 bits LSB first, GAP
// hold cycles of bit 7 per byte, then TAIL hold cycles after the last byte.
module tb_prog_stream_tx;

   localparam int unsigned GAP  = 1;
   localparam int unsigned TAIL = 2;
   localparam int unsigned CW   = 11;

   logic          clk = 1'b0;
   logic          rst, start, wr_valid;
   logic [CW-1:0] byte_count;
   logic [7:0]    wr_data;
   logic          wr_ready, ser_data, ser_enable, busy, done, underrun;
`ifdef PROG_STREAM_CHECKSUM_EN
   logic [7:0]    checksum;
`endif

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   logic       rec[$];
   logic       exp_q[$];
   logic [7:0] byte_q[$];

   typedef struct {
      logic st;
      logic en;
      logic d;
      logic dn;
      logic bz;
   } vec_t;
   vec_t vec[24];

   prog_stream_tx dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_count (byte_count),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .ser_data   (ser_data),
      .ser_enable (ser_enable),
      .busy       (busy),
      .done       (done),
      .underrun   (underrun)
`ifdef PROG_STREAM_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   always #5 clk = ~clk;

   // Line monitor: every enable-high cycle contributes one recorded bit
   always @(negedge clk) begin
      if (ser_enable) rec.push_back(ser_data);
      if (done) done_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      rec.delete();
      done_cnt = 0;
   endtask

   task automatic pulse_start(input int n);
      byte_count = CW'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      bit acc   = 1'b0;
      int guard = 0;
      wr_valid = 1'b1;
      wr_data  = b;
      while (!acc && guard < 2000) begin
         @(negedge clk);
         acc = wr_ready;
         tick();
         guard++;
      end
      wr_valid = 1'b0;
      chk("push_accepted", 32'(acc), 32'd1);
   endtask

   // Pushes byte_q[from..] with randomly idle cycles, honouring wr_ready
   task automatic writer(input int from);
      int i     = from;
      int guard = 0;
      while (i < byte_q.size() && guard < 5000) begin
         wr_valid = ($urandom_range(7) != 0);
         wr_data  = byte_q[i];
         @(negedge clk);
         if (wr_valid && wr_ready) i++;
         tick();
         guard++;
      end
      wr_valid = 1'b0;
      chk("writer_drained", 32'(i), 32'(byte_q.size()));
   endtask

   task automatic wait_done(input int budget);
      bit found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (done) found = 1'b1;
         tick();
      end
      chk("done_seen", 32'(found), 32'd1);
   endtask

   function automatic void build_exp();
      logic [7:0] b;
      exp_q.delete();
      b = 8'h00;
      foreach (byte_q[k]) begin
         b = byte_q[k];
         for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
         for (int g = 0; g < int'(GAP); g++) exp_q.push_back(b[7]);
      end
      for (int t = 0; t < int'(TAIL); t++) exp_q.push_back(b[7]);
   endfunction

   task automatic check_stream(input string tag);
      int bad = 0;
      build_exp();
      chk({tag, "_len"}, 32'(rec.size()), 32'(exp_q.size()));
      for (int i = 0; i < rec.size() && i < exp_q.size(); i++)
         if (rec[i] !== exp_q[i]) bad++;
      chk({tag, "_bits"}, 32'(bad), 32'd0);
   endtask

   // Matches the recorded stream allowing extra holds of bit 7 only between bytes
   function automatic int stall_match();
      int idx = 0;
      logic [7:0] b;
      logic p7 = 1'b0;
      foreach (byte_q[k]) begin
         b = byte_q[k];
         if (k > 0) while (idx < rec.size() && rec[idx] === p7) idx++;
         for (int i = 0; i < 8; i++) begin
            if (idx >= rec.size() || rec[idx] !== b[i]) return 0;
            idx++;
         end
         p7 = b[7];
         for (int g = 0; g < int'(GAP); g++) begin
            if (idx >= rec.size() || rec[idx] !== p7) return 0;
            idx++;
         end
      end
      for (int t = 0; t < int'(TAIL); t++) begin
         if (idx >= rec.size() || rec[idx] !== p7) return 0;
         idx++;
      end
      return (idx == rec.size()) ? 1 : 0;
   endfunction

   function automatic void setv(input int i, input logic st, input logic en,
                                input logic d, input logic dn, input logic bz);
      vec[i].st = st;
      vec[i].en = en;
      vec[i].d  = d;
      vec[i].dn = dn;
      vec[i].bz = bz;
   endfunction

   initial begin
      int en_seen;
      int n, pre;
      logic [7:0] sum;

      // Cycle table for bytes 0x13,0x00 with byte_count=2; cycle 0 carries start,
      // cycle 6 carries a stray start that must be ignored.
      setv(0, 1, 0, 0, 0, 0);
      setv(1, 0, 0, 0, 0, 1);
      setv(2, 0, 1, 1, 0, 1);
      setv(3, 0, 1, 1, 0, 1);
      setv(4, 0, 1, 0, 0, 1);
      setv(5, 0, 1, 0, 0, 1);
      setv(6, 1, 1, 1, 0, 1);
      setv(7, 0, 1, 0, 0, 1);
      setv(8, 0, 1, 0, 0, 1);
      setv(9, 0, 1, 0, 0, 1);
      setv(10, 0, 1, 0, 0, 1);
      for (int i = 11; i < 22; i++) setv(i, 0, 1, 0, 0, 1);
      setv(22, 0, 0, 0, 1, 0);
      setv(23, 0, 0, 0, 0, 0);

      rst = 1'b1; start = 1'b0; byte_count = '0; wr_valid = 1'b0; wr_data = 8'h00;
      tick(); tick();
      rst = 1'b0;

      // Reset values
      @(negedge clk);
      chk("rst_ser_data", 32'(ser_data), 32'd0);
      chk("rst_ser_enable", 32'(ser_enable), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd1);
      tick();

      // Framing table: 0x13, 0x00
      push_byte(8'h13);
      push_byte(8'h00);
      clear_mon();
      byte_count = CW'(2);
      foreach (vec[i]) begin
         start = vec[i].st;
         @(negedge clk);
         chk($sformatf("vec%0d", i), 32'({ser_enable, ser_data, done, busy}),
             32'({vec[i].en, vec[i].d, vec[i].dn, vec[i].bz}));
         tick();
      end
      start = 1'b0;
      chk("table_enable_cycles", 32'(rec.size()), 32'd20);
      chk("table_done_count", 32'(done_cnt), 32'd1);
      chk("table_underrun", 32'(underrun), 32'd0);

      // Fill to full, then stream 20 bytes while the rest are written
      byte_q.delete();
      for (int i = 0; i < 20; i++) byte_q.push_back(8'($urandom));
      for (int i = 0; i < 16; i++) push_byte(byte_q[i]);
      wr_valid = 1'b1;
      wr_data  = byte_q[16];
      @(negedge clk);
      chk("full_after_16", 32'(wr_ready), 32'd0);
      wr_valid = 1'b0;
      tick();
      clear_mon();
      pulse_start(20);
      fork
         writer(16);
         wait_done(600);
      join
      check_stream("fill20");
      chk("fill20_underrun", 32'(underrun), 32'd0);
      chk("fill20_done_count", 32'(done_cnt), 32'd1);

      // Underrun: third byte arrives late; each byte's bit 0 differs from the prior bit 7
      byte_q.delete();
      byte_q.push_back(8'h81);
      byte_q.push_back(8'h80);
      byte_q.push_back(8'h5A);
      push_byte(8'h81);
      clear_mon();
      pulse_start(3);
      fork
         begin
            repeat (3) tick();
            push_byte(8'h80);
            repeat (26) tick();
            push_byte(8'h5A);
         end
         wait_done(400);
      join
      chk("underrun_set", 32'(underrun), 32'd1);
      chk("underrun_stream_order", 32'(stall_match()), 32'd1);
      chk("underrun_stalled", 32'(rec.size() > 29), 32'd1);
      chk("underrun_done_count", 32'(done_cnt), 32'd1);

      // Zero-length transfer: done pulses once, enable never rises, underrun clears
      clear_mon();
      pulse_start(0);
      @(negedge clk);
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
      chk("zero_underrun_cleared", 32'(underrun), 32'd0);
      tick();
      @(negedge clk);
      chk("zero_done_once", 32'(done), 32'd0);
      repeat (4) tick();
      chk("zero_no_enable", 32'(rec.size()), 32'd0);
      chk("zero_done_count", 32'(done_cnt), 32'd1);

      // Reset during bit 4 of the second byte
      push_byte(8'hA5);
      push_byte(8'h3C);
      push_byte(8'h77);
      pulse_start(3);
      en_seen = 0;
      for (int i = 0; i < 100 && en_seen < 14; i++) begin
         @(negedge clk);
         if (ser_enable) en_seen++;
         if (en_seen == 14) rst = 1'b1;
         else tick();
      end
      chk("rst_point_reached", 32'(en_seen), 32'd14);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ser_enable", 32'(ser_enable), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_wr_ready", 32'(wr_ready), 32'd1);
      chk("abort_done", 32'(done), 32'd0);
      tick();
      byte_q.delete();
      byte_q.push_back(8'h96);
      byte_q.push_back(8'h01);
      push_byte(8'h96);
      push_byte(8'h01);
      clear_mon();
      pulse_start(2);
      wait_done(100);
      check_stream("after_rst");
      chk("after_rst_underrun", 32'(underrun), 32'd0);

`ifdef PROG_STREAM_CHECKSUM_EN
      push_byte(8'hFF);
      push_byte(8'h02);
      push_byte(8'h10);
      pulse_start(3);
      wait_done(100);
      chk("checksum_ff_02_10", 32'(checksum), 32'h11);
`endif

      // Randomized transfers against the stream model
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(30, 1);
         byte_q.delete();
         sum = 8'h00;
         for (int i = 0; i < n; i++) begin
            byte_q.push_back(8'($urandom));
            sum = sum + byte_q[i];
         end
         pre = (n < 2) ? n : $urandom_range((n < 16) ? n : 16, 2);
         for (int i = 0; i < pre; i++) push_byte(byte_q[i]);
         clear_mon();
         pulse_start(n);
         fork
            writer(pre);
            wait_done(n * 12 + 100);
         join
         check_stream($sformatf("rand%0d", r));
         chk($sformatf("rand%0d_enable_cycles", r), 32'(rec.size()), 32'(n * (8 + GAP) + TAIL));
         chk($sformatf("rand%0d_underrun", r), 32'(underrun), 32'd0);
         chk($sformatf("rand%0d_done_count", r), 32'(done_cnt), 32'd1);
`ifdef PROG_STREAM_CHECKSUM_EN
         chk($sformatf("rand%0d_checksum", r), 32'(checksum), 32'(sum));
`endif
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
